hdmi_fetch_ctrl: RTL

Line-fetch sequencer for the HDMI output path. It turns the display core's frame and line event pulses (read_go, read_next_line, read_done) into a sequence of single-outstanding burst read requests toward the memory master, and these bursts fill the pixel FIFO ahead of scan-out. It computes per-line byte counts from resolution and pixel format, advances the line address by a stride, throttles on FIFO space, and flags line underruns.

---
 rtl/hdmi_fetch_ctrl.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/hdmi_fetch_ctrl.sv
// Line-fetch sequencer for the HDMI output path: converts frame/line events into
// single-outstanding burst read requests that keep the pixel FIFO ahead of scan-out.
//
// state     | meaning
// IDLE      | no frame active, waiting for read_go
// ARM       | next burst sized, waiting for FIFO space
// REQ       | burst request presented, waiting for req_ready
// WAIT      | burst accepted, waiting for burst_done
// LINE_DONE | whole line fetched, waiting for read_next_line
module hdmi_fetch_ctrl #(
    parameter int BURST_BYTES      = 256,
    parameter int FIFO_DEPTH_WORDS = 512,
    parameter int ADDR_W           = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [15:0]       stride,
    input  logic [10:0]       hres,
    input  logic              num_bytes_per_pixel,
    input  logic              read_go,
    input  logic              read_next_line,
    input  logic              read_done,
    input  logic [9:0]        fifo_level,
    output logic              req_valid,
    output logic [ADDR_W-1:0] req_addr,
    output logic [15:0]       req_len,
    input  logic              req_ready,
    input  logic              burst_done,
    output logic              busy,
    output logic              underrun,
    output logic [10:0]       line_count
);
    typedef enum logic [2:0] {IDLE, ARM, REQ, WAIT, LINE_DONE} state_t;

    localparam logic [15:0] BURST_LEN  = 16'(BURST_BYTES);
    localparam logic [16:0] FIFO_WORDS = 17'(FIFO_DEPTH_WORDS);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] line_addr_q, line_addr_d;
    logic [15:0]       stride_q, stride_d;
    logic              fmt_q, fmt_d;
    logic [15:0]       remaining_q, remaining_d;
    logic              outstanding_q, outstanding_d;
    logic              stop_q, stop_d;
    logic              abort_q, abort_d;
    logic              underrun_d;
    logic [10:0]       line_count_d;
    logic [ADDR_W-1:0] req_addr_d;
    logic [15:0]       req_len_d;

    logic              sync_rst;
    logic [15:0]       line_bytes;
    logic [15:0]       burst_len;
    logic [16:0]       words_after;
    logic              fifo_has_room;
    logic              ev_stop;
    logic              ev_abort;

    function automatic logic [15:0] bytes_for(input logic [10:0] h, input logic fmt);
        return fmt ? {3'b000, h, 2'b00} : {4'b0000, h, 1'b0};
    endfunction

    assign sync_rst      = reset | ~start;
    assign line_bytes    = bytes_for(hres, fmt_q);
    assign burst_len     = (remaining_q > BURST_LEN) ? BURST_LEN : remaining_q;
    assign words_after   = {7'd0, fifo_level} + {3'd0, burst_len[15:2]};
    assign fifo_has_room = (words_after <= FIFO_WORDS);

    // Events pending against the in-flight request; read_done beats read_next_line.
    assign ev_stop  = stop_q | read_done;
    assign ev_abort = abort_q | (read_next_line & ~read_done);

    assign req_valid = (state_q == REQ);
    assign busy      = (state_q != IDLE);

    always_comb begin
        state_d       = state_q;
        line_addr_d   = line_addr_q;
        stride_d      = stride_q;
        fmt_d         = fmt_q;
        remaining_d   = remaining_q;
        outstanding_d = outstanding_q;
        stop_d        = stop_q;
        abort_d       = abort_q;
        underrun_d    = underrun;
        line_count_d  = line_count;
        req_addr_d    = req_addr;
        req_len_d     = req_len;

        case (state_q)
            IDLE: begin
                if (read_go) begin
                    fmt_d        = num_bytes_per_pixel;
                    stride_d     = stride;
                    line_addr_d  = base_addr;
                    remaining_d  = bytes_for(hres, num_bytes_per_pixel);
                    line_count_d = 11'd1;
                    underrun_d   = 1'b0;
                    stop_d       = 1'b0;
                    abort_d      = 1'b0;
                    state_d      = ARM;
                end
            end
            ARM: begin
                if (read_done) begin
                    state_d = IDLE;
                end else if (read_next_line) begin
                    underrun_d   = 1'b1;
                    line_addr_d  = line_addr_q + ADDR_W'(stride_q);
                    remaining_d  = line_bytes;
                    line_count_d = line_count + 11'd1;
                end else if (fifo_has_room) begin
                    req_addr_d = line_addr_q + ADDR_W'(line_bytes - remaining_q);
                    req_len_d  = burst_len;
                    state_d    = REQ;
                end
            end
            REQ: begin
                stop_d  = ev_stop;
                abort_d = ev_abort;
                if (read_next_line && !read_done) underrun_d = 1'b1;
                if (req_ready) begin
                    outstanding_d = 1'b1;
                    remaining_d   = remaining_q - req_len;
                    state_d       = WAIT;
                end
            end
            WAIT: begin
                stop_d  = ev_stop;
                abort_d = ev_abort;
                if (read_next_line && !read_done) underrun_d = 1'b1;
                if (burst_done && outstanding_q) begin
                    outstanding_d = 1'b0;
                    if (ev_stop) begin
                        stop_d  = 1'b0;
                        abort_d = 1'b0;
                        state_d = IDLE;
                    end else if (ev_abort) begin
                        abort_d      = 1'b0;
                        line_addr_d  = line_addr_q + ADDR_W'(stride_q);
                        remaining_d  = line_bytes;
                        line_count_d = line_count + 11'd1;
                        state_d      = ARM;
                    end else if (remaining_q != 16'd0) begin
                        state_d = ARM;
                    end else begin
                        state_d = LINE_DONE;
                    end
                end
            end
            LINE_DONE: begin
                if (read_done) begin
                    state_d = IDLE;
                end else if (read_next_line) begin
                    line_addr_d  = line_addr_q + ADDR_W'(stride_q);
                    remaining_d  = line_bytes;
                    line_count_d = line_count + 11'd1;
                    state_d      = ARM;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (sync_rst) begin
            state_q       <= IDLE;
            line_addr_q   <= '0;
            stride_q      <= '0;
            fmt_q         <= 1'b0;
            remaining_q   <= '0;
            outstanding_q <= 1'b0;
            stop_q        <= 1'b0;
            abort_q       <= 1'b0;
            underrun      <= 1'b0;
            line_count    <= '0;
            req_addr      <= '0;
            req_len       <= '0;
        end else begin
            state_q       <= state_d;
            line_addr_q   <= line_addr_d;
            stride_q      <= stride_d;
            fmt_q         <= fmt_d;
            remaining_q   <= remaining_d;
            outstanding_q <= outstanding_d;
            stop_q        <= stop_d;
            abort_q       <= abort_d;
            underrun      <= underrun_d;
            line_count    <= line_count_d;
            req_addr      <= req_addr_d;
            req_len       <= req_len_d;
        end
    end
endmodule
